bus_arbiter: RTL and testbench

Two-master arbiter for the system bus. It grants bus ownership to one of two command-issuing masters (e.g. two `command_processor` instances) using round-robin priority, and muxes the granted master's address/data/burst/slave-select/instruction onto the shared bus. Ownership is held until the transaction completes, the master withdraws its request, or a watchdog timeout expires.

---
 rtl/system_bus_pkg.sv | 21 ++
 rtl/bus_arbiter_if.sv | 50 +++++
 rtl/bus_field_mux.sv | 50 +++++
 rtl/bus_arbiter.sv | 121 ++++++++++++
 tb/tb_bus_arbiter.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/system_bus_pkg.sv
// rtl/system_bus_pkg.sv - shared system bus widths, instruction codes and arbiter states
package system_bus_pkg;

   localparam int ADDR_LEN_DEF       = 12;
   localparam int DATA_LEN_DEF       = 8;
   localparam int BURST_LEN_DEF      = 12;
   localparam int SLAVE_LEN_DEF      = 2;
   localparam int TIMEOUT_CYCLES_DEF = 1024;

   // Only bit 1 distinguishes "no instruction" (2'b0x) from an active one.
   localparam logic [1:0] INSTR_NONE  = 2'b00;
   localparam logic [1:0] INSTR_WRITE = 2'b10;
   localparam logic [1:0] INSTR_READ  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_BUSY     = 2'd1,
      ST_HANDOVER = 2'd2
   } arb_state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - two-master request/grant and shared bus field bundle
interface bus_arbiter_if #(
   parameter int ADDR_LEN  = system_bus_pkg::ADDR_LEN_DEF,
   parameter int DATA_LEN  = system_bus_pkg::DATA_LEN_DEF,
   parameter int BURST_LEN = system_bus_pkg::BURST_LEN_DEF,
   parameter int SLAVE_LEN = system_bus_pkg::SLAVE_LEN_DEF
);

   logic                 m1_req;
   logic                 m2_req;
   logic [ADDR_LEN-1:0]  m1_address;
   logic [ADDR_LEN-1:0]  m2_address;
   logic [DATA_LEN-1:0]  m1_data;
   logic [DATA_LEN-1:0]  m2_data;
   logic [BURST_LEN-1:0] m1_burst_num;
   logic [BURST_LEN-1:0] m2_burst_num;
   logic [SLAVE_LEN-1:0] m1_slave_select;
   logic [SLAVE_LEN-1:0] m2_slave_select;
   logic [1:0]           m1_instruction;
   logic [1:0]           m2_instruction;
   logic                 tx_done;
   logic                 rx_done;

   logic                 m1_grant;
   logic                 m2_grant;
   logic [ADDR_LEN-1:0]  address;
   logic [DATA_LEN-1:0]  data;
   logic [BURST_LEN-1:0] burst_num;
   logic [SLAVE_LEN-1:0] slave_select;
   logic [1:0]           instruction;
   logic                 bus_busy;
   logic                 timeout;

   modport slave (
      input  m1_req, m2_req, m1_address, m2_address, m1_data, m2_data,
             m1_burst_num, m2_burst_num, m1_slave_select, m2_slave_select,
             m1_instruction, m2_instruction, tx_done, rx_done,
      output m1_grant, m2_grant, address, data, burst_num, slave_select,
             instruction, bus_busy, timeout
   );

   modport master (
      output m1_req, m2_req, m1_address, m2_address, m1_data, m2_data,
             m1_burst_num, m2_burst_num, m1_slave_select, m2_slave_select,
             m1_instruction, m2_instruction, tx_done, rx_done,
      input  m1_grant, m2_grant, address, data, burst_num, slave_select,
             instruction, bus_busy, timeout
   );

endinterface

// File: rtl/bus_field_mux.sv
// rtl/bus_field_mux.sv - combinational 2:1 bus field mux, zero when nothing granted
module bus_field_mux
   import system_bus_pkg::*;
#(
   parameter int ADDR_LEN  = ADDR_LEN_DEF,
   parameter int DATA_LEN  = DATA_LEN_DEF,
   parameter int BURST_LEN = BURST_LEN_DEF,
   parameter int SLAVE_LEN = SLAVE_LEN_DEF
) (
   input  logic                 sel_m1,
   input  logic                 sel_m2,
   input  logic [ADDR_LEN-1:0]  m1_address,
   input  logic [ADDR_LEN-1:0]  m2_address,
   input  logic [DATA_LEN-1:0]  m1_data,
   input  logic [DATA_LEN-1:0]  m2_data,
   input  logic [BURST_LEN-1:0] m1_burst_num,
   input  logic [BURST_LEN-1:0] m2_burst_num,
   input  logic [SLAVE_LEN-1:0] m1_slave_select,
   input  logic [SLAVE_LEN-1:0] m2_slave_select,
   input  logic [1:0]           m1_instruction,
   input  logic [1:0]           m2_instruction,
   output logic [ADDR_LEN-1:0]  address,
   output logic [DATA_LEN-1:0]  data,
   output logic [BURST_LEN-1:0] burst_num,
   output logic [SLAVE_LEN-1:0] slave_select,
   output logic [1:0]           instruction
);

   always_comb begin
      address      = '0;
      data         = '0;
      burst_num    = '0;
      slave_select = '0;
      instruction  = INSTR_NONE;
      if (sel_m1) begin
         address      = m1_address;
         data         = m1_data;
         burst_num    = m1_burst_num;
         slave_select = m1_slave_select;
         instruction  = m1_instruction;
      end else if (sel_m2) begin
         address      = m2_address;
         data         = m2_data;
         burst_num    = m2_burst_num;
         slave_select = m2_slave_select;
         instruction  = m2_instruction;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin two-master bus arbiter with watchdog reclaim
module bus_arbiter
   import system_bus_pkg::*;
#(
   parameter int ADDR_LEN       = ADDR_LEN_DEF,
   parameter int DATA_LEN       = DATA_LEN_DEF,
   parameter int BURST_LEN      = BURST_LEN_DEF,
   parameter int SLAVE_LEN      = SLAVE_LEN_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic          clk,
   input  logic          reset,
   bus_arbiter_if.slave  bus
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   arb_state_t      state, state_next;
   logic            grant1, grant1_next;
   logic            grant2, grant2_next;
   logic            last_m2, last_m2_next;
   logic            timeout_q, timeout_next;
   logic [WD_W-1:0] wd, wd_next;

   logic owner_req, done, wd_fire, pick_m1;

   assign owner_req = grant1 ? bus.m1_req : bus.m2_req;
   assign done      = bus.tx_done | bus.rx_done;
   assign wd_fire   = (wd == WD_LAST);
   // On a tie the master that was not served last wins.
   assign pick_m1   = bus.m1_req & (~bus.m2_req | last_m2);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         grant1    <= 1'b0;
         grant2    <= 1'b0;
         last_m2   <= 1'b1;
         timeout_q <= 1'b0;
         wd        <= '0;
      end else begin
         state     <= state_next;
         grant1    <= grant1_next;
         grant2    <= grant2_next;
         last_m2   <= last_m2_next;
         timeout_q <= timeout_next;
         wd        <= wd_next;
      end
   end

   always_comb begin
      state_next   = state;
      grant1_next  = grant1;
      grant2_next  = grant2;
      last_m2_next = last_m2;
      timeout_next = 1'b0;
      wd_next      = wd;
      case (state)
         ST_IDLE: begin
            if (bus.m1_req | bus.m2_req) begin
               grant1_next  = pick_m1;
               grant2_next  = ~pick_m1;
               last_m2_next = ~pick_m1;
               wd_next      = '0;
               state_next   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (done | ~owner_req | wd_fire) begin
               grant1_next  = 1'b0;
               grant2_next  = 1'b0;
               // A completion on the same edge means the bus was not actually stuck.
               timeout_next = wd_fire & ~done;
               state_next   = ST_HANDOVER;
            end else begin
               wd_next = wd + 1'b1;
            end
         end
         ST_HANDOVER: begin
            state_next = ST_IDLE;
         end
         default: begin
            grant1_next = 1'b0;
            grant2_next = 1'b0;
            state_next  = ST_IDLE;
         end
      endcase
   end

   assign bus.m1_grant = grant1;
   assign bus.m2_grant = grant2;
   assign bus.bus_busy = (state == ST_BUSY);
   assign bus.timeout  = timeout_q;

   bus_field_mux #(
      .ADDR_LEN  (ADDR_LEN),
      .DATA_LEN  (DATA_LEN),
      .BURST_LEN (BURST_LEN),
      .SLAVE_LEN (SLAVE_LEN)
   ) u_field_mux (
      .sel_m1          (grant1),
      .sel_m2          (grant2),
      .m1_address      (bus.m1_address),
      .m2_address      (bus.m2_address),
      .m1_data         (bus.m1_data),
      .m2_data         (bus.m2_data),
      .m1_burst_num    (bus.m1_burst_num),
      .m2_burst_num    (bus.m2_burst_num),
      .m1_slave_select (bus.m1_slave_select),
      .m2_slave_select (bus.m2_slave_select),
      .m1_instruction  (bus.m1_instruction),
      .m2_instruction  (bus.m2_instruction),
      .address         (bus.address),
      .data            (bus.data),
      .burst_num       (bus.burst_num),
      .slave_select    (bus.slave_select),
      .instruction     (bus.instruction)
   );

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - vector table and scoreboard bench for bus_arbiter
module tb_bus_arbiter;
   import system_bus_pkg::*;

   typedef struct {
      logic m1, m2, tx, rx, rst;
      logic g1, g2, to;
   } vec_t;

   logic clk;
   logic reset;
   int   errs;
   int   checks;

   vec_t        vecs[$];
   logic [39:0] exp_q[$];

   bus_arbiter_if bus_i ();

   bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [39:0] pack_exp(logic g1, logic g2, logic to);
      logic [39:0] r;
      r = {g1, g2, g1 | g2, to, 36'h0};
      if (g1)
         r[35:0] = {12'h0A3, 8'h5A, 12'h010, 2'b01, INSTR_WRITE};
      else if (g2)
         r[35:0] = {12'h3C4, 8'hC3, 12'h020, 2'b10, INSTR_READ};
      return r;
   endfunction

   function automatic logic [39:0] pack_got();
      return {bus_i.m1_grant, bus_i.m2_grant, bus_i.bus_busy, bus_i.timeout,
              bus_i.address, bus_i.data, bus_i.burst_num, bus_i.slave_select,
              bus_i.instruction};
   endfunction

   task automatic check(input string name, input logic [39:0] got, input logic [39:0] expv);
      checks++;
      if (got !== expv) begin
         errs++;
         $display("FAIL %s: got=%h expected=%h", name, got, expv);
      end
   endtask

   task automatic v(input logic m1, input logic m2, input logic tx, input logic rx,
                    input logic g1, input logic g2, input logic to, input logic rst);
      vec_t e;
      e.m1 = m1; e.m2 = m2; e.tx = tx; e.rx = rx; e.rst = rst;
      e.g1 = g1; e.g2 = g2; e.to = to;
      vecs.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic async_reset_check();
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_immediate", pack_got(), pack_exp(1'b0, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      check("async_reset_held", pack_got(), pack_exp(1'b0, 1'b0, 1'b0));
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      errs   = 0;
      checks = 0;
      reset  = 1'b0;
      bus_i.m1_req = 1'b0;            bus_i.m2_req = 1'b0;
      bus_i.m1_address = 12'h0A3;     bus_i.m2_address = 12'h3C4;
      bus_i.m1_data = 8'h5A;          bus_i.m2_data = 8'hC3;
      bus_i.m1_burst_num = 12'h010;   bus_i.m2_burst_num = 12'h020;
      bus_i.m1_slave_select = 2'b01;  bus_i.m2_slave_select = 2'b10;
      bus_i.m1_instruction = INSTR_WRITE;
      bus_i.m2_instruction = INSTR_READ;
      bus_i.tx_done = 1'b0;           bus_i.rx_done = 1'b0;

      // m1 m2 tx rx | g1 g2 to | reset-before
      repeat (20) v(0,0,0,0, 0,0,0, 0);
      v(0,0,1,0, 0,0,0, 0);
      v(0,0,0,1, 0,0,0, 0);
      // m1 alone, tx_done five cycles after grant
      repeat (5) v(1,0,0,0, 1,0,0, 0);
      v(1,0,1,0, 0,0,0, 0);
      v(0,0,0,0, 0,0,0, 0);
      v(0,0,0,0, 0,0,0, 0);
      // m2 owns the bus, m1 requests mid-transaction and waits
      v(0,1,0,0, 0,1,0, 0);
      v(0,1,0,0, 0,1,0, 0);
      v(1,1,0,0, 0,1,0, 0);
      v(1,1,0,0, 0,1,0, 0);
      v(1,1,0,1, 0,0,0, 0);
      v(1,0,0,0, 0,0,0, 0);
      v(1,0,0,0, 1,0,0, 0);
      // owner drops req together with tx_done: one release
      v(0,0,1,0, 0,0,0, 0);
      v(0,0,0,0, 0,0,0, 0);
      v(0,0,0,0, 0,0,0, 0);
      // watchdog expiry after 8 busy cycles
      repeat (8) v(1,0,0,0, 1,0,0, 0);
      v(1,0,0,0, 0,0,1, 0);
      v(0,0,0,0, 0,0,0, 0);
      v(0,0,0,0, 0,0,0, 0);
      // rx_done on the expiry cycle suppresses the pulse
      repeat (8) v(1,0,0,0, 1,0,0, 0);
      v(1,0,0,1, 0,0,0, 0);
      v(0,0,0,0, 0,0,0, 0);
      // tie with m1 served last: m2 first
      v(1,1,0,0, 0,1,0, 0);
      v(1,1,0,1, 0,0,0, 0);
      v(1,1,0,0, 0,0,0, 0);
      v(1,1,0,0, 1,0,0, 0);
      v(1,1,0,0, 1,0,0, 0);
      // reset while m1 owns the bus; the tie afterwards must go to m1 again
      v(1,1,0,0, 1,0,0, 1);
      v(1,1,0,1, 0,0,0, 0);
      v(1,1,0,0, 0,0,0, 0);
      v(1,1,0,0, 0,1,0, 0);
      v(1,1,1,0, 0,0,0, 0);
      v(1,1,0,0, 0,0,0, 0);
      v(1,1,0,0, 1,0,0, 0);
      v(1,1,0,1, 0,0,0, 0);
      v(1,1,0,0, 0,0,0, 0);
      v(1,1,0,0, 0,1,0, 0);
      v(1,1,0,1, 0,0,0, 0);
      v(0,0,0,0, 0,0,0, 0);
      v(0,0,0,0, 0,0,0, 0);

      @(posedge clk);
      #1;
      check("reset_low", pack_got(), pack_exp(1'b0, 1'b0, 1'b0));
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) async_reset_check();
         bus_i.m1_req  = vecs[i].m1;
         bus_i.m2_req  = vecs[i].m2;
         bus_i.tx_done = vecs[i].tx;
         bus_i.rx_done = vecs[i].rx;
         exp_q.push_back(pack_exp(vecs[i].g1, vecs[i].g2, vecs[i].to));
         tick();
         if (exp_q.size() == 0) begin
            errs++;
            checks++;
            $display("FAIL scoreboard_empty: vector %0d", i);
         end else begin
            check($sformatf("vec%0d", i), pack_got(), exp_q.pop_front());
         end
      end

      checks++;
      if (exp_q.size() != 0) begin
         errs++;
         $display("FAIL scoreboard_leftover: got=%0d expected=0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
